// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor: each stage adds one CHUNK-bit slice and registers its carry,
// while the remaining operand bits and the finished low sum bits travel alongside the beat.
module pipelined_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    if ((WIDTH < CHUNK) || (WIDTH % CHUNK != 0)) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    // Handshake: a beat crosses an interface on a rising edge only when valid && ready.
    // The stall is global, so the whole pipe moves only when the output slot is empty or
    // being drained; in_ready is that same condition, combinationally.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int REM = WIDTH - k * CHUNK;  // operand bits not yet added on entry
        logic [REM-1:0]         a_i;
        logic [REM-1:0]         b_i;
        logic                   c_i;
        logic                   v_i;
        logic [CHUNK:0]         add;
        logic [(k+1)*CHUNK-1:0] s_n;
        logic                   v_r;
        logic                   c_r;
        logic [(k+1)*CHUNK-1:0] s_r;

        if (k == 0) begin : g_src
            assign a_i = a;
            assign b_i = sub ? ~b : b;
            assign c_i = sub | cin;
            assign v_i = in_valid;
            assign s_n = add[CHUNK-1:0];
        end else begin : g_chain
            assign a_i = stg[k-1].g_fwd.a_r;
            assign b_i = stg[k-1].g_fwd.b_r;
            assign c_i = stg[k-1].c_r;
            assign v_i = stg[k-1].v_r;
            assign s_n = {add[CHUNK-1:0], stg[k-1].s_r};
        end

        assign add = {1'b0, a_i[CHUNK-1:0]} + {1'b0, b_i[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_i};

        always_ff @(posedge clk) begin
            if (rst) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                s_r <= '0;
            end else if (advance) begin
                v_r <= v_i;
                c_r <= add[CHUNK];
                s_r <= s_n;
            end
        end

        if (k < LAST) begin : g_fwd
            logic [REM-CHUNK-1:0] a_r;
            logic [REM-CHUNK-1:0] b_r;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (advance) begin
                    a_r <= a_i[REM-1:CHUNK];
                    b_r <= b_i[REM-1:CHUNK];
                end
            end
        end else begin : g_last
            logic ovf_r;

            // The top slice holds both operand sign bits and the result sign bit.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_r <= 1'b0;
                end else if (advance) begin
                    ovf_r <= (a_i[CHUNK-1] == b_i[CHUNK-1]) && (add[CHUNK-1] != a_i[CHUNK-1]);
                end
            end
        end
    end

    assign out_valid = stg[LAST].v_r;
    assign sum       = stg[LAST].s_r;
    assign cout      = stg[LAST].c_r;
    assign ovf       = stg[LAST].g_last.ovf_r;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder at three geometries (32/8, 8/8, 16/4): results are scored against
// plain integer arithmetic of A + B' + carry, with overflow judged on the signed value range.
module tb_pipelined_adder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        v0 = 1'b0, r0, cin0 = 1'b0, sub0 = 1'b0, ov0, ordy0 = 1'b1, cout0, ovf0;
    logic [31:0] a0 = '0, b0 = '0, sum0;
    logic        v1 = 1'b0, r1, cin1 = 1'b0, sub1 = 1'b0, ov1, ordy1 = 1'b1, cout1, ovf1;
    logic [7:0]  a1 = '0, b1 = '0, sum1;
    logic        v2 = 1'b0, r2, cin2 = 1'b0, sub2 = 1'b0, ov2, ordy2 = 1'b1, cout2, ovf2;
    logic [15:0] a2 = '0, b2 = '0, sum2;

    pipelined_adder #(.WIDTH(32), .CHUNK(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .a(a0), .b(b0), .cin(cin0),
        .sub(sub0), .out_valid(ov0), .out_ready(ordy0), .sum(sum0), .cout(cout0), .ovf(ovf0)
    );

    pipelined_adder #(.WIDTH(8), .CHUNK(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .a(a1), .b(b1), .cin(cin1),
        .sub(sub1), .out_valid(ov1), .out_ready(ordy1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .a(a2), .b(b2), .cin(cin2),
        .sub(sub2), .out_valid(ov2), .out_ready(ordy2), .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_acc0 = 0, n_acc1 = 0, n_acc2 = 0;
    int          n_emit0 = 0, n_emit1 = 0, n_emit2 = 0;
    bit          lat_on = 1'b0;
    logic [33:0] exp_q0[$];
    logic [33:0] exp_q1[$];
    logic [33:0] exp_q2[$];
    int          acc_q0[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: {ovf, cout, sum} for a w-bit operation, sum zero-extended to 32 bits.
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        longint m, ua, ub, c, t, sa, sb, ss;
        logic [31:0] s;
        logic co, ov;
        m  = (longint'(1) << w) - 1;
        ua = longint'(a) & m;
        ub = sub ? (~longint'(b) & m) : (longint'(b) & m);
        c  = sub ? 1 : longint'(cin);
        t  = ua + ub + c;
        s  = t[31:0] & m[31:0];
        co = t[w];
        sa = (ua > (m >> 1)) ? ua - m - 1 : ua;
        sb = (ub > (m >> 1)) ? ub - m - 1 : ub;
        ss = sa + sb + c;
        ov = (ss > (m >> 1)) || (ss < -(m >> 1) - 1);
        return {ov, co, s};
    endfunction

    function automatic logic [31:0] rnd(input int w);
        logic [31:0] m;
        m = 32'hFFFF_FFFF >> (32 - w);
        case ($urandom_range(0, 7))
            0:       return m;
            1:       return m ^ (m >> 1);
            2:       return m >> 1;
            3:       return 32'd0;
            default: return $urandom & m;
        endcase
    endfunction

    // Accepted beats push their expected result; presented results are compared to the head
    // every cycle (so a stalled beat must hold its value) and popped when taken.
    always @(negedge clk) begin
        int lat;
        if (rst) begin
            exp_q0.delete();
            exp_q1.delete();
            exp_q2.delete();
            acc_q0.delete();
        end else begin
            if (v0 && r0) begin
                exp_q0.push_back(model(32, a0, b0, cin0, sub0));
                acc_q0.push_back(cyc);
                n_acc0++;
            end
            if (v1 && r1) begin
                exp_q1.push_back(model(8, {24'd0, a1}, {24'd0, b1}, cin1, sub1));
                n_acc1++;
            end
            if (v2 && r2) begin
                exp_q2.push_back(model(16, {16'd0, a2}, {16'd0, b2}, cin2, sub2));
                n_acc2++;
            end
            if (ov0) begin
                if (exp_q0.size() == 0) begin
                    check("d0_spurious_out_valid", 64'(ov0), 64'd0);
                end else begin
                    check("d0_result", {30'd0, ovf0, cout0, sum0}, {30'd0, exp_q0[0]});
                    if (ordy0) begin
                        void'(exp_q0.pop_front());
                        lat = cyc - acc_q0.pop_front();
                        if (lat_on) check("d0_latency", 64'(lat), 64'd4);
                        n_emit0++;
                    end
                end
            end
            if (ov1) begin
                if (exp_q1.size() == 0) begin
                    check("d1_spurious_out_valid", 64'(ov1), 64'd0);
                end else begin
                    check("d1_result", {30'd0, ovf1, cout1, 24'd0, sum1}, {30'd0, exp_q1[0]});
                    if (ordy1) begin
                        void'(exp_q1.pop_front());
                        n_emit1++;
                    end
                end
            end
            if (ov2) begin
                if (exp_q2.size() == 0) begin
                    check("d2_spurious_out_valid", 64'(ov2), 64'd0);
                end else begin
                    check("d2_result", {30'd0, ovf2, cout2, 16'd0, sum2}, {30'd0, exp_q2[0]});
                    if (ordy2) begin
                        void'(exp_q2.pop_front());
                        n_emit2++;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send0(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                         input logic ts);
        int n;
        n = 0;
        a0 = ta; b0 = tb; cin0 = tc; sub0 = ts; v0 = 1'b1;
        @(negedge clk);
        while (!r0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!r0) check("send0_accept_timeout", 64'(r0), 64'd1);
        @(posedge clk);
        #1;
        v0 = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q0.size() + exp_q1.size() + exp_q2.size()) != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_queues_empty", 64'(exp_q0.size() + exp_q1.size() + exp_q2.size()), 64'd0);
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        #200_000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: time limit hit at cycle %0d, want completion before it", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int e, e0, e1, e2, t0, t1, t2, l1, l2, g;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 64'(ov0), 64'd0);
        check("reset_sum", 64'(sum0), 64'd0);
        check("reset_cout_ovf", {62'd0, cout0, ovf0}, 64'd0);
        check("reset_in_ready", 64'(r0), 64'd1);
        check("reset_out_valid_w8_w16", {62'd0, ov1, ov2}, 64'd0);
        @(posedge clk);
        #1;

        // Carry ripple through every stage, then sign/borrow corners.
        lat_on = 1'b1;
        send0(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_drain();
        send0(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send0(32'd5, 32'd7, 1'b0, 1'b1);
        send0(32'd5, 32'd7, 1'b1, 1'b1);
        send0(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        send0(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
        wait_drain();

        // Back-to-back stream.
        e = n_emit0;
        for (int i = 0; i < 8; i++) begin
            a0 = 32'(i); b0 = 32'(i) * 32'h0101_0101; cin0 = 1'(i); sub0 = 1'b0; v0 = 1'b1;
            @(negedge clk);
            check("stream_in_ready", 64'(r0), 64'd1);
            @(posedge clk);
            #1;
        end
        v0 = 1'b0;
        wait_drain();
        check("stream_emit_count", 64'(n_emit0 - e), 64'd8);

        // Backpressure while the first result is presented.
        lat_on = 1'b0;
        e = n_emit0;
        t0 = n_acc0;
        fork
            begin
                for (int i = 0; i < 6; i++) send0($urandom, $urandom, 1'($urandom), 1'($urandom));
            end
            begin
                int n;
                n = 0;
                while (!ov0 && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("bp_first_out_valid", 64'(ov0), 64'd1);
                ordy0 = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("bp_in_ready_low", 64'(r0), 64'd0);
                    check("bp_out_valid_held", 64'(ov0), 64'd1);
                    @(posedge clk);
                    #1;
                end
                ordy0 = 1'b1;
            end
        join
        wait_drain();
        check("bp_accept_count", 64'(n_acc0 - t0), 64'd6);
        check("bp_emit_count", 64'(n_emit0 - e), 64'd6);

        // Reset with three beats in flight.
        v0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a0 = $urandom; b0 = $urandom; cin0 = 1'($urandom); sub0 = 1'($urandom);
            @(posedge clk);
            #1;
        end
        v0 = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(ov0), 64'd0);
        check("midrst_sum", 64'(sum0), 64'd0);
        check("midrst_cout_ovf", {62'd0, cout0, ovf0}, 64'd0);
        check("midrst_in_ready", 64'(r0), 64'd1);
        e = n_emit0;
        repeat (10) @(negedge clk);
        check("midrst_no_emit", 64'(n_emit0 - e), 64'd0);
        @(posedge clk);
        #1;

        // Latency of the narrow geometries.
        a1 = 8'hFF; b1 = 8'h01; cin1 = 1'b0; sub1 = 1'b0; v1 = 1'b1;
        a2 = 16'hFFFF; b2 = 16'h0001; cin2 = 1'b1; sub2 = 1'b0; v2 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        v2 = 1'b0;
        l1 = 0;
        l2 = 0;
        for (int n = 1; n <= 12; n++) begin
            if (ov1 && l1 == 0) l1 = n;
            if (ov2 && l2 == 0) l2 = n;
            @(posedge clk);
            #1;
        end
        check("latency_w8_c8", 64'(l1), 64'd1);
        check("latency_w16_c4", 64'(l2), 64'd4);
        wait_drain();

        // Random traffic with input gaps and output stalls on all three geometries.
        t0 = n_acc0; t1 = n_acc1; t2 = n_acc2;
        e0 = n_emit0; e1 = n_emit1; e2 = n_emit2;
        g = 0;
        while ((n_acc0 < t0 + 1000 || n_acc1 < t1 + 1000 || n_acc2 < t2 + 1000) && g < 20000) begin
            v0 = (n_acc0 < t0 + 1000) && ($urandom_range(0, 3) != 0);
            a0 = rnd(32); b0 = rnd(32); cin0 = 1'($urandom); sub0 = 1'($urandom);
            v1 = (n_acc1 < t1 + 1000) && ($urandom_range(0, 3) != 0);
            a1 = 8'(rnd(8)); b1 = 8'(rnd(8)); cin1 = 1'($urandom); sub1 = 1'($urandom);
            v2 = (n_acc2 < t2 + 1000) && ($urandom_range(0, 3) != 0);
            a2 = 16'(rnd(16)); b2 = 16'(rnd(16)); cin2 = 1'($urandom); sub2 = 1'($urandom);
            ordy0 = ($urandom_range(0, 3) != 0);
            ordy1 = ($urandom_range(0, 3) != 0);
            ordy2 = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            g++;
        end
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        ordy0 = 1'b1; ordy1 = 1'b1; ordy2 = 1'b1;
        check("random_accepts_w32", 64'(n_acc0 - t0), 64'd1000);
        check("random_accepts_w8", 64'(n_acc1 - t1), 64'd1000);
        check("random_accepts_w16", 64'(n_acc2 - t2), 64'd1000);
        wait_drain();
        check("random_emits_w32", 64'(n_emit0 - e0), 64'd1000);
        check("random_emits_w8", 64'(n_emit1 - e1), 64'd1000);
        check("random_emits_w16", 64'(n_emit2 - e2), 64'd1000);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
